// File: rtl/matrix_scan_driver_if.sv
// matrix_scan_driver_if: bitmap load handshake between an image source and the scan driver
interface matrix_scan_driver_if #(
    parameter int ROWS = 7,
    parameter int COLS = 5
);
    logic [ROWS*COLS-1:0] map_in;
    logic                 map_valid;
    logic                 map_ready;
    modport master (output map_in, map_valid, input map_ready);
    modport slave  (input map_in, map_valid, output map_ready);
endinterface

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: double-buffered, row-multiplexed LED matrix scanner with guard gaps
module matrix_scan_driver #(
    parameter int ROWS  = 7,
    parameter int COLS  = 5,
    parameter int DWELL = 1000,
    parameter int GUARD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_scan_driver_if.slave  bus,
    input  logic                 blank,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_start
);
    localparam int CMAX = DWELL > GUARD ? DWELL : GUARD;
    localparam int CW = $clog2(CMAX + 1);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GD_LAST = CW'(GUARD - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    typedef enum logic {GAP, DRIVE} state_t;
    state_t               st, nst;
    logic [CW-1:0]        cnt, ncnt;
    logic [RW-1:0]        row, nrow;
    logic [ROWS*COLS-1:0] active, shadow;
    logic                 shadow_full, last, wrap, swap, accept;
    assign bus.map_ready = ~shadow_full;
    assign accept = bus.map_valid & ~shadow_full;
    always_comb begin
        last = st == DRIVE ? cnt == DW_LAST : cnt == GD_LAST;
        wrap = row == R_LAST;
        nst  = last ? (st == GAP ? DRIVE : GAP) : st;
        ncnt = last ? '0 : cnt + 1'b1;
        nrow = (st == DRIVE && last) ? (wrap ? '0 : row + 1'b1) : row;
        swap = st == DRIVE && last && wrap;
    end
    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= GAP;
            cnt         <= '0;
            row         <= '0;
            active      <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            st          <= nst;
            cnt         <= ncnt;
            row         <= nrow;
            shadow_full <= accept | (shadow_full & ~swap);
            if (accept) shadow <= bus.map_in;
            if (swap && shadow_full) active <= shadow;
            row_sel     <= nst == DRIVE ? ROWS'(1) << nrow : '0;
            col_data    <= (nst == DRIVE && !blank) ? active[nrow*COLS +: COLS] : '0;
            frame_start <= st == GAP && nst == DRIVE && row == '0;
        end
    end
    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(row_sel));
    a_gap_dark: assert property (@(posedge clk) disable iff (reset) row_sel == '0 |-> col_data == '0);
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: randomized scoreboard bench against a frame-arithmetic reference model
module tb_matrix_scan_driver;
    localparam int ROWS = 7, COLS = 5, DWELL = 4, GUARD = 2;
    localparam int SLOT = GUARD + DWELL;
    localparam int PER = ROWS * SLOT;
    localparam int NB = ROWS * COLS;
    typedef struct {
        logic [ROWS-1:0] rs;
        logic [COLS-1:0] cd;
        logic            fs;
        logic            rdy;
    } exp_t;
    logic clk = 0, reset = 1, blank = 0;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
    logic frame_start;
    int tests = 0, fails = 0;
    matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .bus(bus), .blank(blank),
        .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    int t_m = 0, ph, r;
    bit live = 0, drv, sf_m = 0, acc, blank_prev = 0;
    logic [NB-1:0] act_m = '0, sh_m = '0;
    // Reference model: time since reset gives row/phase, frames swap every PER clocks
    always @(negedge clk) begin
        exp_t e;
        if (live) begin
            ph = t_m % PER;
            r = ph / SLOT;
            drv = (ph % SLOT) >= GUARD;
            e.rs = drv ? ROWS'(1 << r) : '0;
            e.cd = (drv && !blank_prev) ? act_m[r*COLS +: COLS] : '0;
            e.fs = ph == GUARD;
            e.rdy = !sf_m;
            q.push_back(e);
        end
        if (reset) begin
            t_m = 0; act_m = '0; sh_m = '0; sf_m = 0; blank_prev = 0; live = 1;
        end else if (live) begin
            acc = bus.map_valid && !sf_m;
            if (t_m % PER == PER - 1 && sf_m) begin act_m = sh_m; sf_m = 0; end
            if (acc) begin sh_m = bus.map_in; sf_m = 1; end
            blank_prev = blank;
            t_m++;
        end
    end
    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s t=%0d got %h expected %h", n, t_m, got, want);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("row_sel", 32'(row_sel), 32'(e.rs));
            chk("col_data", 32'(col_data), 32'(e.cd));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("map_ready", 32'(bus.map_ready), 32'(e.rdy));
        end
    end
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic load(logic [NB-1:0] img);
        bit ok = 0;
        bus.map_in = img;
        bus.map_valid = 1;
        for (int i = 0; i < 4 * PER && !ok; i++) begin
            @(negedge clk);
            ok = bus.map_ready;
            @(posedge clk);
            #1;
        end
        bus.map_valid = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL load_accept got not-accepted expected accepted");
        end
    endtask
    task automatic wait_phase(int p);
        for (int i = 0; i < 2 * PER && t_m % PER != p; i++) step(1);
    endtask
    logic [NB-1:0] diag_a, diag_b;
    initial begin
        bus.map_in = '0;
        bus.map_valid = 0;
        diag_a = '0;
        diag_b = '0;
        for (int k = 0; k < ROWS; k++) begin
            diag_a[k*COLS + k % COLS] = 1'b1;
            diag_b[k*COLS + (COLS - 1 - k % COLS)] = 1'b1;
        end
        step(3);
        reset = 0;
        step(2 * PER);
        load({NB{1'b1}});
        step(2 * PER);
        load(diag_a);
        load(diag_b);
        step(3 * PER);
        wait_phase(PER - 1);
        load(NB'({$urandom(), $urandom()}));
        step(2 * PER);
        wait_phase(2 * SLOT);
        blank = 1;
        wait_phase(4 * SLOT);
        blank = 0;
        step(PER);
        load(diag_a);
        step(PER + 5);
        wait_phase(4 * SLOT + GUARD + 1);
        reset = 1;
        step(1);
        reset = 0;
        step(PER + 10);
        for (int it = 0; it < 25; it++) begin
            for (int c = 0, n = $urandom_range(0, 60); c < n; c++) begin
                blank = ($urandom % 6) == 0;
                step(1);
            end
            load(NB'({$urandom(), $urandom()}));
        end
        blank = 0;
        step(2 * PER);
        @(negedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
